aram_sp_ctrl: RTL and testbench
===============================

# aram_sp_ctrl

Synchronous front-end controller for the asynchronous single-port RAM (`ASYNCH_RAM_SP`). It accepts read/write requests from clocked logic through a valid/ready handshake. It sequences the RAM's address, bidirectional data bus and `wr_rd_en` strobe with programmable setup, pulse and wait cycles, and returns read data as a registered one-cycle response. It sits directly upstream of the RAM and replaces ad-hoc task-driven stimulus with cycle-exact, contention-free bus control.

## Interface
- `data_width`, 8, RAM word width
- `address_width`, 4, RAM address width
- `wr_pulse_cyc`, 2, cycles `ram_wr_rd_en` is held high per write; ≥1
- `rd_wait_cyc`, 2, cycles the address is held before read data is captured; ≥1

Ports:
- `clk`  in  1  single clock; all logic is rising-edge
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `req_valid`  in  1  request present
- `req_ready`  out  1  controller idle; request accepted when both `req_valid` and `req_ready` are high at a rising edge
- `req_we`  in  1  1 = write, 0 = read
- `req_addr`  in  `address_width`  target address
- `req_wdata`  in  `data_width`  write data
- `rsp_valid`  out  1  one-cycle pulse, read data valid
- `rsp_rdata`  out  `data_width`  captured read data
- `ram_address`  out  `address_width`  to RAM address
- `ram_wr_rd_en`  out  1  to RAM; 1 = write, 0 = read
- `ram_data`  inout  `data_width`  RAM data bus; driven only while `ram_wr_rd_en`=1, else high-Z

## Operation
- FSM states: IDLE, W_SETUP, W_PULSE, W_RECOV, R_WAIT, R_DONE.
- IDLE: `req_ready`=1. On accept, register `req_addr` into `ram_address` and `req_wdata` into the write latch. Go to W_SETUP if `req_we`=1, else R_WAIT.
- W_SETUP (1 cycle): address stable, `ram_wr_rd_en`=0, bus Z.
- W_PULSE (`wr_pulse_cyc` cycles): `ram_wr_rd_en`=1, bus driven with the latched data.
- W_RECOV (1 cycle): `ram_wr_rd_en`=0, bus Z, address held. Then go to IDLE.
- R_WAIT (`rd_wait_cyc` cycles): `ram_wr_rd_en`=0, address held. On the final edge, sample `ram_data` into `rsp_rdata` and set `rsp_valid`.
- R_DONE (1 cycle): `rsp_valid`=1. Then go to IDLE.
- Writes produce no response.
- `rsp_valid` has no backpressure; the consumer must take it in that cycle.
- `ram_address` changes only on accept, i.e. never while `ram_wr_rd_en`=1.
- `ram_wr_rd_en` and the bus-drive enable come from a single register, so they are identical and the bus is never driven during a read.
- Request inputs are ignored when `req_ready`=0. Inputs that change after accept have no effect.
- `ram_address` retains its last value in IDLE.

## Timing
- Reset values (asynchronous, immediate): state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `ram_address`=0, `ram_wr_rd_en`=0, `ram_data` high-Z.
- Accept at edge T.
- Write: `ram_wr_rd_en` is high in cycles T+2 … T+1+`wr_pulse_cyc`. `req_ready` returns high in cycle T+3+`wr_pulse_cyc`.
- Read: `rsp_valid` is high in cycle T+1+`rd_wait_cyc`. `req_ready` returns high in cycle T+2+`rd_wait_cyc`.
- Back-to-back: a request held valid is accepted on the first edge `req_ready`=1, with no extra bubble.
- Wait-state counter width is `$clog2(max(wr_pulse_cyc, rd_wait_cyc)+1)`. It loads on state entry and counts down to 1; there is no wrap.
- Reset mid-pulse: `ram_wr_rd_en` drops and the bus releases asynchronously. The write is aborted and no response is issued.

## Structure
- Package `aram_sp_pkg`:
  - state encoding localparams
  - default `wr_pulse_cyc` and `rd_wait_cyc`
  - `ram_wr_rd_en` polarity constants (WR=1, RD=0)
- Sub-module `aram_wait_cnt`: loadable down-counter with a `done` flag, instantiated once and shared by W_PULSE and R_WAIT.
- Tri-state bus: one continuous assign in the top level.

## Test plan
- Write `8'h0F` to `4'hA` (defaults) -> `ram_address`=A from T+1; `ram_wr_rd_en` high exactly cycles T+2..T+3 with `ram_data`=0F; Z at T+1 and T+4; `req_ready` high at T+5.
- Read `4'hA` after that write -> `rsp_valid` single pulse at T+3 with `rsp_rdata`=`8'h0F`; `ram_wr_rd_en` stays 0 throughout.
- Back-to-back: write F0→B, read B, read A with `req_valid` held -> responses F0 then 0F; no cycle with the bus driven while `ram_wr_rd_en`=0; no address change while `ram_wr_rd_en`=1.
- `req_valid` with `req_addr` toggling while busy -> ignored; only the accepted address appears on `ram_address`.
- Assert `rst_n` during W_PULSE -> `ram_wr_rd_en`=0 and bus Z in the same cycle; after release `req_ready`=1, `rsp_valid`=0, `ram_address`=0.
- Run with `wr_pulse_cyc`=1 and `rd_wait_cyc`=5 -> write strobe exactly 1 cycle; read response at T+6.

Source files
------------

// File: rtl/aram_sp_pkg.sv
// aram_sp_pkg: shared state encoding, default timing and strobe polarity for
// the asynchronous single-port RAM front-end controller.
`default_nettype none

package aram_sp_pkg;

  localparam logic [2:0] c_ST_IDLE    = 3'd0;
  localparam logic [2:0] c_ST_W_SETUP = 3'd1;
  localparam logic [2:0] c_ST_W_PULSE = 3'd2;
  localparam logic [2:0] c_ST_W_RECOV = 3'd3;
  localparam logic [2:0] c_ST_R_WAIT  = 3'd4;
  localparam logic [2:0] c_ST_R_DONE  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE    = c_ST_IDLE,
    S_W_SETUP = c_ST_W_SETUP,
    S_W_PULSE = c_ST_W_PULSE,
    S_W_RECOV = c_ST_W_RECOV,
    S_R_WAIT  = c_ST_R_WAIT,
    S_R_DONE  = c_ST_R_DONE
  } state_e;

  localparam int c_DEF_WR_PULSE_CYC = 2;
  localparam int c_DEF_RD_WAIT_CYC  = 2;

  localparam logic c_RAM_WR = 1'b1;
  localparam logic c_RAM_RD = 1'b0;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/aram_wait_cnt.sv
// aram_wait_cnt: loadable wait-state down-counter; holds at 1 and flags done
// there, so a stale count can never wrap into a long stall.
`default_nettype none

module aram_wait_cnt #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_done
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt > CNT_W'(1))) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_done = (r_cnt == CNT_W'(1));

endmodule

`default_nettype wire

// File: rtl/aram_sp_ctrl.sv
// aram_sp_ctrl: valid/ready front-end for the asynchronous single-port RAM,
// sequencing address, write strobe and tri-state data bus with wait states.
`default_nettype none

module aram_sp_ctrl
  import aram_sp_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 4,
  parameter int WR_PULSE_CYC  = c_DEF_WR_PULSE_CYC,
  parameter int RD_WAIT_CYC   = c_DEF_RD_WAIT_CYC
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     rsp_valid,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  output logic [ADDRESS_WIDTH-1:0] ram_address,
  output logic                     ram_wr_rd_en,
  inout  wire  [DATA_WIDTH-1:0]    ram_data
);

  localparam int c_CNT_W = $clog2(max2(WR_PULSE_CYC, RD_WAIT_CYC) + 1);
  localparam logic [c_CNT_W-1:0] c_WR_LOAD = c_CNT_W'(WR_PULSE_CYC);
  localparam logic [c_CNT_W-1:0] c_RD_LOAD = c_CNT_W'(RD_WAIT_CYC);

  state_e                     r_state;
  state_e                     w_next;
  logic [ADDRESS_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]      r_wdata;
  logic                       r_wr_en;
  logic                       r_rsp_valid;
  logic [DATA_WIDTH-1:0]      r_rsp_rdata;
  logic                       w_accept;
  logic                       w_cnt_load;
  logic [c_CNT_W-1:0]         w_cnt_load_val;
  logic                       w_cnt_dec;
  logic                       w_cnt_done;
  logic                       w_rd_capture;

  aram_wait_cnt #(
    .CNT_W (c_CNT_W)
  ) u_wait_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_load_val),
    .i_dec      (w_cnt_dec),
    .o_done     (w_cnt_done)
  );

  assign w_accept     = (r_state == S_IDLE) && req_valid;
  assign w_rd_capture = (r_state == S_R_WAIT) && w_cnt_done;

  always_comb begin
    w_next         = r_state;
    w_cnt_load     = 1'b0;
    w_cnt_load_val = c_RD_LOAD;
    w_cnt_dec      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_next     = req_we ? S_W_SETUP : S_R_WAIT;
          w_cnt_load = !req_we;
        end
      end
      S_W_SETUP: begin
        w_next         = S_W_PULSE;
        w_cnt_load     = 1'b1;
        w_cnt_load_val = c_WR_LOAD;
      end
      S_W_PULSE: begin
        if (w_cnt_done) w_next = S_W_RECOV;
        else            w_cnt_dec = 1'b1;
      end
      S_W_RECOV: w_next = S_IDLE;
      S_R_WAIT: begin
        if (w_cnt_done) w_next = S_R_DONE;
        else            w_cnt_dec = 1'b1;
      end
      S_R_DONE: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // The strobe is registered from next-state so the bus enable and
  // ram_wr_rd_en are literally the same flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wr_en     <= c_RAM_RD;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_state     <= w_next;
      r_wr_en     <= (w_next == S_W_PULSE) ? c_RAM_WR : c_RAM_RD;
      r_rsp_valid <= w_rd_capture;
      if (w_accept) begin
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      if (w_rd_capture) begin
        r_rsp_rdata <= ram_data;
      end
    end
  end

  assign ram_data     = (r_wr_en == c_RAM_WR) ? r_wdata : {DATA_WIDTH{1'bz}};
  assign ram_wr_rd_en = r_wr_en;
  assign ram_address  = r_addr;
  assign req_ready    = (r_state == S_IDLE);
  assign rsp_valid    = r_rsp_valid;
  assign rsp_rdata    = r_rsp_rdata;

endmodule

`default_nettype wire

// File: tb/tb_aram_sp_ctrl.sv
// tb_aram_sp_ctrl: directed bench with a cycle-schedule model of the controller
// and a behavioural asynchronous RAM on the shared data bus.
`default_nettype none

module tb_aram_sp_ctrl;

  localparam int P  = 2;
  localparam int R  = 2;
  localparam int P2 = 1;
  localparam int R2 = 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_ready, req_we;
  logic [3:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic [3:0] ram_address;
  logic       ram_wr_rd_en;
  wire  [7:0] ram_data;
  logic [7:0] ram_mem [16];

  logic       b_valid, b_ready, b_we;
  logic [3:0] b_addr;
  logic [7:0] b_wdata;
  logic       b_rsp_valid;
  logic [7:0] b_rsp_rdata;
  logic [3:0] b_ram_addr;
  logic       b_ram_en;
  wire  [7:0] b_ram_data;
  logic [7:0] ram2_mem [16];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  aram_sp_ctrl #(.DATA_WIDTH(8), .ADDRESS_WIDTH(4), .WR_PULSE_CYC(P), .RD_WAIT_CYC(R)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .ram_address(ram_address), .ram_wr_rd_en(ram_wr_rd_en), .ram_data(ram_data));

  aram_sp_ctrl #(.DATA_WIDTH(8), .ADDRESS_WIDTH(4), .WR_PULSE_CYC(P2), .RD_WAIT_CYC(R2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(b_valid), .req_ready(b_ready), .req_we(b_we),
    .req_addr(b_addr), .req_wdata(b_wdata), .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
    .ram_address(b_ram_addr), .ram_wr_rd_en(b_ram_en), .ram_data(b_ram_data));

  function automatic logic [7:0] init_val(input int i);
    return 8'(8'h80 + i);
  endfunction

  // Behavioural RAMs: drive read data whenever not strobed, latch on strobe.
  assign ram_data   = ram_wr_rd_en ? 8'hzz : ram_mem[ram_address];
  assign b_ram_data = b_ram_en ? 8'hzz : ram2_mem[b_ram_addr];

  initial begin
    for (int i = 0; i < 16; i++) begin
      ram_mem[i]  = init_val(i);
      ram2_mem[i] = init_val(i);
    end
    forever begin
      @(posedge clk);
      if (ram_wr_rd_en) ram_mem[ram_address] = ram_data;
      if (b_ram_en)     ram2_mem[b_ram_addr] = b_ram_data;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Schedule model: cycle k ends at edge k; accept at edge T fixes every
  // future output by arithmetic on T.
  int         edge_n   = 0;
  int         ready_at = 0;
  int         we_s     = 1;
  int         we_e     = 0;
  int         rsp_at   = -1;
  logic [3:0] exp_addr  = '0;
  logic [7:0] exp_rdata = '0;
  logic [7:0] m_wdata   = '0;
  logic [7:0] m_mem [16];
  bit         pend_w  = 0;
  logic [3:0] pw_addr;
  bit         pend_r  = 0;
  logic [7:0] pr_data;

  initial begin
    int c;
    for (int i = 0; i < 16; i++) m_mem[i] = init_val(i);
    forever begin
      @(posedge clk or negedge rst_n);
      if (clk) edge_n++;
      if (!rst_n) begin
        ready_at = 0; we_s = 1; we_e = 0; rsp_at = -1;
        exp_addr = '0; exp_rdata = '0; pend_w = 0; pend_r = 0;
      end else if (clk) begin
        c = edge_n;
        if (pend_w && c == we_s) begin m_mem[pw_addr] = m_wdata; pend_w = 0; end
        if (pend_r && c == rsp_at - 1) begin exp_rdata = pr_data; pend_r = 0; end
        if (c >= ready_at && req_valid) begin
          exp_addr = req_addr;
          if (req_we) begin
            we_s = c + 2; we_e = c + 1 + P; ready_at = c + 3 + P;
            m_wdata = req_wdata; pw_addr = req_addr; pend_w = 1;
          end else begin
            rsp_at = c + 1 + R; ready_at = c + 2 + R;
            pr_data = m_mem[req_addr]; pend_r = 1;
          end
        end
      end
    end
  end

  initial begin
    int cur;
    bit exp_we;
    forever begin
      @(negedge clk);
      cur    = edge_n + 1;
      exp_we = (cur >= we_s) && (cur <= we_e);
      chk("m_ready", {31'd0, req_ready}, {31'd0, cur >= ready_at});
      chk("m_wren", {31'd0, ram_wr_rd_en}, {31'd0, exp_we});
      chk("m_rspv", {31'd0, rsp_valid}, {31'd0, cur == rsp_at});
      chk("m_rdata", {24'd0, rsp_rdata}, {24'd0, exp_rdata});
      chk("m_addr", {28'd0, ram_address}, {28'd0, exp_addr});
      if (exp_we) chk("m_bus_wr", {24'd0, ram_data}, {24'd0, m_wdata});
      else        chk("m_bus_rd", {24'd0, ram_data}, {24'd0, ram_mem[ram_address]});
    end
  end

  logic [7:0] rsp_q [$];
  initial forever begin
    @(negedge clk);
    if (rsp_valid) rsp_q.push_back(rsp_rdata);
  end

  task automatic send(input logic we, input logic [3:0] a, input logic [7:0] d, input bit hold);
    int n;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    n = 0;
    while (req_ready !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    if (n >= 40) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: got ready=%0b expected 1", req_ready);
    end
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
  endtask

  logic       tr_en  [1:8];
  logic       tr_rdy [1:8];
  logic       tr_rv  [1:8];
  logic [7:0] tr_rd  [1:8];
  logic [7:0] tr_dat [1:8];
  logic [3:0] tr_adr [1:8];

  task automatic capture(input int n, input bit second);
    for (int k = 1; k <= n; k++) begin
      tr_en[k]  = second ? b_ram_en    : ram_wr_rd_en;
      tr_rdy[k] = second ? b_ready     : req_ready;
      tr_rv[k]  = second ? b_rsp_valid : rsp_valid;
      tr_rd[k]  = second ? b_rsp_rdata : rsp_rdata;
      tr_dat[k] = second ? b_ram_data  : ram_data;
      tr_adr[k] = second ? b_ram_addr  : ram_address;
      if (k < n) @(negedge clk);
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    b_valid = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rspv", {31'd0, rsp_valid}, 32'd0);
    chk("rst_wren", {31'd0, ram_wr_rd_en}, 32'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);

    // Write 0F to A: strobe exactly T+2..T+3, ready back at T+5.
    send(1'b1, 4'hA, 8'h0F, 1'b0);
    capture(5, 1'b0);
    chk("wr_addr_t1", {28'd0, tr_adr[1]}, 32'hA);
    chk("wr_en_t1", {31'd0, tr_en[1]}, 32'd0);
    chk("wr_en_t2", {31'd0, tr_en[2]}, 32'd1);
    chk("wr_en_t3", {31'd0, tr_en[3]}, 32'd1);
    chk("wr_en_t4", {31'd0, tr_en[4]}, 32'd0);
    chk("wr_bus_t2", {24'd0, tr_dat[2]}, 32'h0F);
    chk("wr_rdy_t4", {31'd0, tr_rdy[4]}, 32'd0);
    chk("wr_rdy_t5", {31'd0, tr_rdy[5]}, 32'd1);

    // Read A: single response pulse at T+3 carrying 0F.
    send(1'b0, 4'hA, 8'h00, 1'b0);
    capture(4, 1'b0);
    chk("rd_rspv_t2", {31'd0, tr_rv[2]}, 32'd0);
    chk("rd_rspv_t3", {31'd0, tr_rv[3]}, 32'd1);
    chk("rd_rdata_t3", {24'd0, tr_rd[3]}, 32'h0F);
    chk("rd_rspv_t4", {31'd0, tr_rv[4]}, 32'd0);
    chk("rd_en_t2", {31'd0, tr_en[2]}, 32'd0);

    // Back-to-back with valid held throughout.
    rsp_q.delete();
    send(1'b1, 4'hB, 8'hF0, 1'b1);
    send(1'b0, 4'hB, 8'h00, 1'b1);
    send(1'b0, 4'hA, 8'h00, 1'b0);
    repeat (6) @(negedge clk);
    chk("b2b_count", rsp_q.size(), 32'd2);
    if (rsp_q.size() >= 2) begin
      chk("b2b_rsp0", {24'd0, rsp_q[0]}, 32'hF0);
      chk("b2b_rsp1", {24'd0, rsp_q[1]}, 32'h0F);
    end

    // Request fields toggle while busy; only the value present at accept counts.
    send(1'b1, 4'h2, 8'hC3, 1'b1);
    n = 0;
    while (req_ready !== 1'b1 && n < 40) begin
      req_addr = 4'(n + 8); req_wdata = 8'(n * 7); req_we = n[0];
      @(negedge clk); n++;
    end
    req_addr = 4'h7; req_we = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    chk("tog_addr", {28'd0, ram_address}, 32'h7);
    repeat (6) @(negedge clk);

    // Reset in the middle of the write pulse.
    send(1'b1, 4'h3, 8'h5A, 1'b0);
    @(negedge clk);
    chk("rstp_en_before", {31'd0, ram_wr_rd_en}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstp_en", {31'd0, ram_wr_rd_en}, 32'd0);
    chk("rstp_bus", {24'd0, ram_data}, {24'd0, init_val(0)});
    @(negedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rstp_ready", {31'd0, req_ready}, 32'd1);
    chk("rstp_rspv", {31'd0, rsp_valid}, 32'd0);
    chk("rstp_addr", {28'd0, ram_address}, 32'd0);
    repeat (3) @(negedge clk);

    // Second instance: 1-cycle strobe, 5-cycle read wait.
    b_valid = 1'b1; b_we = 1'b1; b_addr = 4'h5; b_wdata = 8'h3C;
    n = 0;
    while (b_ready !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    @(negedge clk);
    b_valid = 1'b0;
    capture(4, 1'b1);
    chk("p1_en_t1", {31'd0, tr_en[1]}, 32'd0);
    chk("p1_en_t2", {31'd0, tr_en[2]}, 32'd1);
    chk("p1_bus_t2", {24'd0, tr_dat[2]}, 32'h3C);
    chk("p1_en_t3", {31'd0, tr_en[3]}, 32'd0);
    chk("p1_rdy_t4", {31'd0, tr_rdy[4]}, 32'd1);
    b_valid = 1'b1; b_we = 1'b0; b_addr = 4'h5;
    n = 0;
    while (b_ready !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    @(negedge clk);
    b_valid = 1'b0;
    capture(8, 1'b1);
    chk("r5_rspv_t5", {31'd0, tr_rv[5]}, 32'd0);
    chk("r5_rspv_t6", {31'd0, tr_rv[6]}, 32'd1);
    chk("r5_rdata_t6", {24'd0, tr_rd[6]}, 32'h3C);
    chk("r5_rspv_t7", {31'd0, tr_rv[7]}, 32'd0);
    chk("r5_rdy_t6", {31'd0, tr_rdy[6]}, 32'd0);
    chk("r5_rdy_t7", {31'd0, tr_rdy[7]}, 32'd1);
    chk("r5_en_t4", {31'd0, tr_en[4]}, 32'd0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
